icache_ctrl: RTL and testbench



---
 rtl/icache_ctrl_pkg.sv | 23 ++
 rtl/icache_ctrl.sv | 116 +++++++++++
 tb/tb_icache_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared constants and encodings for the instruction-cache controller:
// cache geometry, memory bus commands and controller states.
package icache_ctrl_pkg;

   localparam int OFF_BITS     = 3;
   localparam int IDX_BITS     = 7;
   localparam int TAG_BITS     = 22;
   localparam int MEM_TAG_BITS = 4;
   localparam int LINE_BITS    = TAG_BITS + IDX_BITS;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: zero-latency hit path, a single
// outstanding tagged LOAD on a miss, and fill (with forwarding) on the matching return.
module icache_ctrl
   import icache_ctrl_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    proc2Icache_en,
   input  logic [63:0]             proc2Icache_addr,
   output logic [63:0]             Icache_data_out,
   output logic                    Icache_valid_out,
   output logic [IDX_BITS-1:0]     rd_idx,
   output logic [TAG_BITS-1:0]     rd_tag,
   input  logic [63:0]             cachemem_data,
   input  logic                    cachemem_valid,
   output logic                    wr_en,
   output logic [IDX_BITS-1:0]     wr_idx,
   output logic [TAG_BITS-1:0]     wr_tag,
   output logic [63:0]             wr_data,
   output logic [1:0]              proc2mem_command,
   output logic [63:0]             proc2mem_addr,
   input  logic [MEM_TAG_BITS-1:0] mem2proc_response,
   input  logic [63:0]             mem2proc_data,
   input  logic [MEM_TAG_BITS-1:0] mem2proc_tag,
   output logic [31:0]             miss_count,
   output logic [1:0]              fsm_state
);

   state_t                  state, state_n;
   logic [IDX_BITS-1:0]     miss_idx, miss_idx_n;
   logic [TAG_BITS-1:0]     miss_tag, miss_tag_n;
   logic [MEM_TAG_BITS-1:0] mem_tag, mem_tag_n;
   logic [31:0]             miss_count_n;
   bus_cmd_t                cmd;

   assign rd_idx           = proc2Icache_addr[OFF_BITS +: IDX_BITS];
   assign rd_tag           = proc2Icache_addr[OFF_BITS+IDX_BITS +: TAG_BITS];
   assign proc2mem_command = cmd;
   assign fsm_state        = state;

   always_comb begin
      state_n          = state;
      miss_idx_n       = miss_idx;
      miss_tag_n       = miss_tag;
      mem_tag_n        = mem_tag;
      miss_count_n     = miss_count;
      cmd              = BUS_NONE;
      proc2mem_addr    = '0;
      wr_en            = 1'b0;
      wr_idx           = '0;
      wr_tag           = '0;
      wr_data          = '0;
      Icache_valid_out = proc2Icache_en & cachemem_valid;
      Icache_data_out  = cachemem_data;

      case (state)
         IDLE: begin
            if (proc2Icache_en && !cachemem_valid) begin
               miss_idx_n    = rd_idx;
               miss_tag_n    = rd_tag;
               cmd           = BUS_LOAD;
               proc2mem_addr = {proc2Icache_addr[63:OFF_BITS], {OFF_BITS{1'b0}}};
               miss_count_n  = miss_count + 32'd1;
               if (mem2proc_response != '0) begin
                  mem_tag_n = mem2proc_response;
                  state_n   = WAIT;
               end else begin
                  state_n   = REQ;
               end
            end
         end
         // Retry uses the latched line so a redirected fetch cannot alter the request.
         REQ: begin
            cmd           = BUS_LOAD;
            proc2mem_addr = {32'b0, miss_tag, miss_idx, {OFF_BITS{1'b0}}};
            if (mem2proc_response != '0) begin
               mem_tag_n = mem2proc_response;
               state_n   = WAIT;
            end
         end
         WAIT: begin
            if (mem2proc_tag == mem_tag) begin
               wr_en   = 1'b1;
               wr_idx  = miss_idx;
               wr_tag  = miss_tag;
               wr_data = mem2proc_data;
               state_n = IDLE;
               // The array still holds the old line this cycle, so forward the return data.
               if (proc2Icache_en &&
                   proc2Icache_addr[31:OFF_BITS] == {miss_tag, miss_idx}) begin
                  Icache_valid_out = 1'b1;
                  Icache_data_out  = mem2proc_data;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         miss_idx   <= '0;
         miss_tag   <= '0;
         mem_tag    <= '0;
         miss_count <= '0;
      end else begin
         state      <= state_n;
         miss_idx   <= miss_idx_n;
         miss_tag   <= miss_tag_n;
         mem_tag    <= mem_tag_n;
         miss_count <= miss_count_n;
      end
   end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios plus a randomized run, all checked
// against a behavioural model of the cache array and the outstanding miss.
module tb_icache_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        en;
   logic [63:0] addr;
   logic [63:0] Icache_data_out;
   logic        Icache_valid_out;
   logic [6:0]  rd_idx;
   logic [21:0] rd_tag;
   logic [63:0] cachemem_data;
   logic        cachemem_valid;
   logic        wr_en;
   logic [6:0]  wr_idx;
   logic [21:0] wr_tag;
   logic [63:0] wr_data;
   logic [1:0]  proc2mem_command;
   logic [63:0] proc2mem_addr;
   logic [3:0]  mem_resp;
   logic [63:0] mem_data;
   logic [3:0]  mem_tag;
   logic [31:0] miss_count;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_errors = 0;

   icache_ctrl dut (
      .clock(clock), .reset(reset),
      .proc2Icache_en(en), .proc2Icache_addr(addr),
      .Icache_data_out(Icache_data_out), .Icache_valid_out(Icache_valid_out),
      .rd_idx(rd_idx), .rd_tag(rd_tag),
      .cachemem_data(cachemem_data), .cachemem_valid(cachemem_valid),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag), .wr_data(wr_data),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .mem2proc_response(mem_resp), .mem2proc_data(mem_data), .mem2proc_tag(mem_tag),
      .miss_count(miss_count), .fsm_state(fsm_state)
   );

   always #5 clock = ~clock;

   // Cache array contents as seen by the environment.
   logic        arr_v [128];
   logic [21:0] arr_t [128];
   logic [63:0] arr_d [128];

   // Outstanding-miss model: is a miss open, has memory accepted it, which line, which tag.
   bit          m_busy;
   bit          m_acc;
   logic [28:0] m_line;
   logic [3:0]  m_mtag;
   logic [31:0] m_misses;

   logic        e_valid, e_wr_en;
   logic [63:0] e_data, e_paddr, e_wr_data;
   logic [1:0]  e_cmd, e_state;
   logic [6:0]  e_wr_idx;
   logic [21:0] e_wr_tag;

   task automatic model_reset();
      m_busy = 0; m_acc = 0; m_line = '0; m_mtag = '0; m_misses = '0;
   endtask

   task automatic model_eval();
      e_valid = en && cachemem_valid;
      e_data = cachemem_data;
      e_cmd = 2'd0; e_paddr = '0;
      e_wr_en = 0; e_wr_idx = '0; e_wr_tag = '0; e_wr_data = '0;
      e_state = !m_busy ? 2'd0 : (!m_acc ? 2'd1 : 2'd2);
      if (!m_busy) begin
         if (en && !cachemem_valid) begin
            e_cmd = 2'd1;
            e_paddr = {addr[63:3], 3'b000};
         end
      end else if (!m_acc) begin
         e_cmd = 2'd1;
         e_paddr = {32'b0, m_line, 3'b000};
      end else if (mem_tag == m_mtag) begin
         e_wr_en = 1;
         e_wr_idx = m_line[6:0];
         e_wr_tag = m_line[28:7];
         e_wr_data = mem_data;
         if (en && addr[31:3] == m_line) begin
            e_valid = 1;
            e_data = mem_data;
         end
      end
   endtask

   task automatic model_step();
      if (!reset) begin
         model_reset();
         return;
      end
      if (!m_busy) begin
         if (en && !cachemem_valid) begin
            m_busy = 1;
            m_line = addr[31:3];
            m_misses = m_misses + 32'd1;
            m_acc = (mem_resp != 0);
            if (mem_resp != 0) m_mtag = mem_resp;
         end
      end else if (!m_acc) begin
         if (mem_resp != 0) begin
            m_acc = 1;
            m_mtag = mem_resp;
         end
      end else if (mem_tag == m_mtag) begin
         arr_v[m_line[6:0]] = 1'b1;
         arr_t[m_line[6:0]] = m_line[28:7];
         arr_d[m_line[6:0]] = mem_data;
         m_busy = 0;
      end
   endtask

   // Present the array read for the current address, settle, and compute expectations.
   task automatic apply();
      int i;
      i = int'(addr[9:3]);
      cachemem_valid = arr_v[i] && (arr_t[i] == addr[31:10]);
      cachemem_data = arr_d[i];
      #1;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic drive(input logic e, input logic [63:0] a, input logic [3:0] r,
                        input logic [3:0] t, input logic [63:0] d);
      en = e; addr = a; mem_resp = r; mem_tag = t; mem_data = d;
      apply();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      drive(1'b0, 64'h0, 4'h0, 4'h0, 64'h0);
      #2;
      n_checks++; if (fsm_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
      n_checks++; if (proc2mem_command !== 2'd0) begin n_errors++; $display("FAIL reset_cmd got %0d exp 0", proc2mem_command); end
      n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got %0b exp 0", wr_en); end
      n_checks++; if (miss_count !== 32'd0) begin n_errors++; $display("FAIL reset_miss_count got %0d exp 0", miss_count); end
      n_checks++; if (Icache_valid_out !== 1'b0 || Icache_data_out !== 64'h0) begin n_errors++; $display("FAIL reset_out got v=%0b d=%0h exp v=0 d=0", Icache_valid_out, Icache_data_out); end
      n_checks++; if (proc2mem_addr !== 64'h0) begin n_errors++; $display("FAIL reset_paddr got %0h exp 0", proc2mem_addr); end
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_hit();
      arr_v[5] = 1'b1; arr_t[5] = 22'h3; arr_d[5] = 64'hAAAA;
      drive(1'b1, 64'hC28, 4'h0, 4'h0, 64'h0);
      n_checks++; if (rd_idx !== 7'd5 || rd_tag !== 22'h3) begin n_errors++; $display("FAIL hit_rd got idx=%0h tag=%0h exp idx=5 tag=3", rd_idx, rd_tag); end
      n_checks++; if (Icache_valid_out !== 1'b1 || Icache_data_out !== 64'hAAAA) begin n_errors++; $display("FAIL hit_out got v=%0b d=%0h exp v=1 d=aaaa", Icache_valid_out, Icache_data_out); end
      n_checks++; if (proc2mem_command !== 2'd0) begin n_errors++; $display("FAIL hit_cmd got %0d exp 0", proc2mem_command); end
      tick();
   endtask

   task automatic test_miss_accept();
      drive(1'b1, 64'h1000, 4'h2, 4'h0, 64'h0);
      n_checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h1000) begin n_errors++; $display("FAIL miss_load got cmd=%0d a=%0h exp cmd=1 a=1000", proc2mem_command, proc2mem_addr); end
      n_checks++; if (Icache_valid_out !== 1'b0) begin n_errors++; $display("FAIL miss_valid got %0b exp 0", Icache_valid_out); end
      tick();
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 64'h1000, 4'h0, 4'h0, 64'h0);
         n_checks++; if (proc2mem_command !== 2'd0 || wr_en !== 1'b0) begin n_errors++; $display("FAIL miss_wait%0d got cmd=%0d wr=%0b exp cmd=0 wr=0", c, proc2mem_command, wr_en); end
         tick();
      end
      drive(1'b1, 64'h1000, 4'h0, 4'h2, 64'hBEEF);
      n_checks++; if (wr_en !== 1'b1 || wr_idx !== 7'd0 || wr_tag !== 22'h4 || wr_data !== 64'hBEEF) begin n_errors++; $display("FAIL miss_fill got wr=%0b i=%0h t=%0h d=%0h exp wr=1 i=0 t=4 d=beef", wr_en, wr_idx, wr_tag, wr_data); end
      n_checks++; if (Icache_valid_out !== 1'b1 || Icache_data_out !== 64'hBEEF) begin n_errors++; $display("FAIL miss_fwd got v=%0b d=%0h exp v=1 d=beef", Icache_valid_out, Icache_data_out); end
      tick();
      n_checks++; if (miss_count !== m_misses || miss_count !== 32'd1) begin n_errors++; $display("FAIL miss_count got %0d exp 1", miss_count); end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 64'h1000, 4'h0, 4'h0, 64'h0);
      n_checks++; if (Icache_valid_out !== 1'b1 || Icache_data_out !== 64'hBEEF || proc2mem_command !== 2'd0) begin n_errors++; $display("FAIL b2b_hit got v=%0b d=%0h cmd=%0d exp v=1 d=beef cmd=0", Icache_valid_out, Icache_data_out, proc2mem_command); end
      tick();
      drive(1'b1, 64'h1408, 4'h4, 4'h0, 64'h0);
      n_checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h1408) begin n_errors++; $display("FAIL b2b_load got cmd=%0d a=%0h exp cmd=1 a=1408", proc2mem_command, proc2mem_addr); end
      tick();
      drive(1'b0, 64'h0, 4'h0, 4'h4, 64'h1234);
      n_checks++; if (wr_en !== 1'b1 || wr_idx !== 7'd1 || wr_tag !== 22'h5) begin n_errors++; $display("FAIL b2b_fill got wr=%0b i=%0h t=%0h exp wr=1 i=1 t=5", wr_en, wr_idx, wr_tag); end
      tick();
   endtask

   task automatic test_retry_tag_filter();
      int writes;
      drive(1'b1, 64'h5010, 4'h0, 4'h0, 64'h0);
      n_checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h5010) begin n_errors++; $display("FAIL retry_0 got cmd=%0d a=%0h exp cmd=1 a=5010", proc2mem_command, proc2mem_addr); end
      tick();
      for (int c = 1; c < 4; c++) begin
         drive(1'b1, 64'h7777_0000_0000_0040, (c == 3) ? 4'h7 : 4'h0, 4'h0, 64'h0);
         n_checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h5010) begin n_errors++; $display("FAIL retry_%0d got cmd=%0d a=%0h exp cmd=1 a=5010", c, proc2mem_command, proc2mem_addr); end
         tick();
      end
      n_checks++; if (fsm_state !== 2'd2 || miss_count !== m_misses) begin n_errors++; $display("FAIL retry_state got st=%0d mc=%0d exp st=2 mc=%0d", fsm_state, miss_count, m_misses); end
      writes = 0;
      drive(1'b0, 64'h0, 4'h0, 4'h3, 64'h1);
      writes += int'(wr_en); tick();
      drive(1'b0, 64'h0, 4'h0, 4'h0, 64'h2);
      writes += int'(wr_en); tick();
      drive(1'b0, 64'h0, 4'h0, 4'h7, 64'hC0DE);
      n_checks++; if (wr_en !== 1'b1 || wr_idx !== 7'd2 || wr_tag !== 22'h14 || wr_data !== 64'hC0DE) begin n_errors++; $display("FAIL filter_fill got wr=%0b i=%0h t=%0h d=%0h exp wr=1 i=2 t=14 d=c0de", wr_en, wr_idx, wr_tag, wr_data); end
      writes += int'(wr_en); tick();
      drive(1'b0, 64'h0, 4'h0, 4'h7, 64'h3);
      writes += int'(wr_en); tick();
      n_checks++; if (writes !== 1) begin n_errors++; $display("FAIL filter_writes got %0d exp 1", writes); end
   endtask

   task automatic test_redirect();
      drive(1'b1, 64'h2000, 4'h1, 4'h0, 64'h0);
      n_checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h2000) begin n_errors++; $display("FAIL redir_load got cmd=%0d a=%0h exp cmd=1 a=2000", proc2mem_command, proc2mem_addr); end
      tick();
      drive(1'b1, 64'h3008, 4'h0, 4'h0, 64'h0);
      n_checks++; if (proc2mem_command !== 2'd0 || fsm_state !== 2'd2) begin n_errors++; $display("FAIL redir_hold got cmd=%0d st=%0d exp cmd=0 st=2", proc2mem_command, fsm_state); end
      tick();
      drive(1'b1, 64'h3008, 4'h0, 4'h1, 64'hD00D);
      n_checks++; if (wr_en !== 1'b1 || wr_idx !== 7'd0 || wr_tag !== 22'h8 || Icache_valid_out !== 1'b0) begin n_errors++; $display("FAIL redir_fill got wr=%0b i=%0h t=%0h v=%0b exp wr=1 i=0 t=8 v=0", wr_en, wr_idx, wr_tag, Icache_valid_out); end
      tick();
      drive(1'b1, 64'h3008, 4'h3, 4'h0, 64'h0);
      n_checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h3008) begin n_errors++; $display("FAIL redir_new got cmd=%0d a=%0h exp cmd=1 a=3008", proc2mem_command, proc2mem_addr); end
      tick();
      drive(1'b1, 64'h3008, 4'h0, 4'h3, 64'hF00D);
      n_checks++; if (wr_en !== 1'b1 || Icache_valid_out !== 1'b1 || Icache_data_out !== 64'hF00D) begin n_errors++; $display("FAIL redir_fwd got wr=%0b v=%0b d=%0h exp wr=1 v=1 d=f00d", wr_en, Icache_valid_out, Icache_data_out); end
      tick();
   endtask

   task automatic test_reset_in_wait();
      drive(1'b1, 64'h4000, 4'h7, 4'h0, 64'h0);
      tick();
      drive(1'b0, 64'h0, 4'h0, 4'h0, 64'h0);
      n_checks++; if (fsm_state !== 2'd2) begin n_errors++; $display("FAIL rst_pre got st=%0d exp 2", fsm_state); end
      reset = 1'b0;
      model_reset();
      #1;
      n_checks++; if (fsm_state !== 2'd0 || miss_count !== 32'd0) begin n_errors++; $display("FAIL rst_async got st=%0d mc=%0d exp st=0 mc=0", fsm_state, miss_count); end
      tick();
      reset = 1'b1;
      drive(1'b0, 64'h0, 4'h0, 4'h7, 64'hBAD);
      n_checks++; if (wr_en !== 1'b0 || fsm_state !== 2'd0 || miss_count !== 32'd0) begin n_errors++; $display("FAIL rst_stale got wr=%0b st=%0d mc=%0d exp wr=0 st=0 mc=0", wr_en, fsm_state, miss_count); end
      tick();
   endtask

   task automatic test_random();
      logic [63:0] a;
      for (int c = 0; c < 600; c++) begin
         a = {$urandom(), 22'($urandom_range(0, 3)), 7'($urandom_range(0, 7)), 3'($urandom())};
         drive($urandom_range(0, 3) != 0, a,
               ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
               ($urandom_range(0, 2) == 0) ? m_mtag : 4'($urandom_range(0, 15)),
               {$urandom(), $urandom()});
         n_checks++; if (Icache_valid_out !== e_valid || (e_valid && Icache_data_out !== e_data)) begin n_errors++; $display("FAIL rnd%0d_out got v=%0b d=%0h exp v=%0b d=%0h", c, Icache_valid_out, Icache_data_out, e_valid, e_data); end
         n_checks++; if (proc2mem_command !== e_cmd || (e_cmd == 2'd1 && proc2mem_addr !== e_paddr)) begin n_errors++; $display("FAIL rnd%0d_bus got cmd=%0d a=%0h exp cmd=%0d a=%0h", c, proc2mem_command, proc2mem_addr, e_cmd, e_paddr); end
         n_checks++; if (wr_en !== e_wr_en || (e_wr_en && (wr_idx !== e_wr_idx || wr_tag !== e_wr_tag || wr_data !== e_wr_data))) begin n_errors++; $display("FAIL rnd%0d_wr got wr=%0b i=%0h t=%0h d=%0h exp wr=%0b i=%0h t=%0h d=%0h", c, wr_en, wr_idx, wr_tag, wr_data, e_wr_en, e_wr_idx, e_wr_tag, e_wr_data); end
         n_checks++; if (rd_idx !== a[9:3] || rd_tag !== a[31:10]) begin n_errors++; $display("FAIL rnd%0d_rd got i=%0h t=%0h exp i=%0h t=%0h", c, rd_idx, rd_tag, a[9:3], a[31:10]); end
         n_checks++; if (fsm_state !== e_state || miss_count !== m_misses) begin n_errors++; $display("FAIL rnd%0d_st got st=%0d mc=%0d exp st=%0d mc=%0d", c, fsm_state, miss_count, e_state, m_misses); end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         arr_v[i] = 1'b0; arr_t[i] = '0; arr_d[i] = '0;
      end
      en = 0; addr = '0; mem_resp = '0; mem_tag = '0; mem_data = '0;
      cachemem_valid = 0; cachemem_data = '0;
      test_reset();
      test_hit();
      test_miss_accept();
      test_back_to_back();
      test_retry_tag_filter();
      test_redirect();
      test_reset_in_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
